// File: rtl/lsu_initiator_if.sv
// -----------------------------------------------------------------------------
// lsu_initiator_if
// Bundles the two handshakes of the load/store initiator:
//   core side  : cpu_req_* (request in), cpu_resp_* / cpu_err* / busy (result out)
//   memory side: mem_req/mem_write/mem_addr/mem_wdata out, mem_ack/mem_rdata in
// Modports:
//   master - the initiator (drives core results and the memory request)
//   slave  - the surroundings (core + memory responder)
// Handshakes: a core request transfers on a rising edge where cpu_req_valid and
// cpu_req_ready are both 1; the core holds its request stable until then.
// A memory access is offered while mem_req=1 with stable write/addr/wdata and
// completes on the rising edge where mem_ack=1 (mem_rdata valid for loads).
// -----------------------------------------------------------------------------
interface lsu_initiator_if;
   logic        cpu_req_valid;
   logic        cpu_req_ready;
   logic        cpu_req_write;
   logic [31:0] cpu_req_addr;
   logic [31:0] cpu_req_wdata;
   logic        cpu_resp_valid;
   logic [31:0] cpu_resp_rdata;
   logic        cpu_err;
   logic [1:0]  cpu_err_code;
   logic        busy;
   logic        mem_req;
   logic        mem_write;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   modport master (
      input  cpu_req_valid, cpu_req_write, cpu_req_addr, cpu_req_wdata,
      input  mem_ack, mem_rdata,
      output cpu_req_ready, cpu_resp_valid, cpu_resp_rdata, cpu_err, cpu_err_code,
      output busy, mem_req, mem_write, mem_addr, mem_wdata
   );

   modport slave (
      output cpu_req_valid, cpu_req_write, cpu_req_addr, cpu_req_wdata,
      output mem_ack, mem_rdata,
      input  cpu_req_ready, cpu_resp_valid, cpu_resp_rdata, cpu_err, cpu_err_code,
      input  busy, mem_req, mem_write, mem_addr, mem_wdata
   );
endinterface

// File: rtl/lsu_initiator.sv
// -----------------------------------------------------------------------------
// lsu_initiator
// Load/store initiator between the CPU datapath and word-addressed data memory.
// Accepts one lw/sw at a time, checks alignment and range, issues a held
// mem_req until mem_ack or timeout, then reports data or an error code.
// Ports:
//   clk        - clock, all state updates on the rising edge
//   rst_lsu_n  - asynchronous active-low reset
//   bus        - lsu_initiator_if.master (core request/response + memory request)
//   dbg_state  - current FSM state (0 IDLE, 1 REQ, 2 RESP, 3 ERR)
// -----------------------------------------------------------------------------
module lsu_initiator #(
   parameter int unsigned TIMEOUT_CYCLES = 15,          // 1..255
   parameter logic [31:0] ADDR_LIMIT     = 32'd1024
) (
   input  logic                   clk,
   input  logic                   rst_lsu_n,
   lsu_initiator_if.master        bus,
   output logic [1:0]             dbg_state
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2,
      ERR  = 2'd3
   } state_e;

   localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);

   localparam logic [1:0] CODE_NONE     = 2'b00;
   localparam logic [1:0] CODE_MISALIGN = 2'b01;
   localparam logic [1:0] CODE_TIMEOUT  = 2'b10;
   localparam logic [1:0] CODE_RANGE    = 2'b11;

   state_e      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        write_q, write_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic [1:0]  code_q, code_d;
   logic [7:0]  cnt_inc;

   always_ff @(posedge clk or negedge rst_lsu_n) begin
      if (!rst_lsu_n) begin
         state_q <= IDLE;
         cnt_q   <= 8'd0;
         write_q <= 1'b0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         rdata_q <= 32'd0;
         code_q  <= CODE_NONE;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         write_q <= write_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         code_q  <= code_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      write_d = write_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      code_d  = code_q;
      cnt_inc = cnt_q + 8'd1;

      case (state_q)
         IDLE: begin
            // Ready is asserted throughout IDLE, so valid alone means accept.
            if (bus.cpu_req_valid) begin
               write_d = bus.cpu_req_write;
               addr_d  = bus.cpu_req_addr;
               wdata_d = bus.cpu_req_wdata;
               // Misalignment is checked first so it wins over out-of-range.
               if (bus.cpu_req_addr[1:0] != 2'b00) begin
                  state_d = ERR;
                  code_d  = CODE_MISALIGN;
               end else if (bus.cpu_req_addr >= ADDR_LIMIT) begin
                  state_d = ERR;
                  code_d  = CODE_RANGE;
               end else begin
                  state_d = REQ;
                  cnt_d   = 8'd0;
               end
            end
         end
         REQ: begin
            // Ack is looked at before the timeout so an ack in the last
            // allowed cycle still completes successfully.
            if (bus.mem_ack) begin
               state_d = RESP;
               rdata_d = write_q ? 32'd0 : bus.mem_rdata;
            end else begin
               cnt_d = cnt_inc;
               if (cnt_inc == TIMEOUT_LIM) begin
                  state_d = ERR;
                  code_d  = CODE_TIMEOUT;
               end
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         ERR: begin
            state_d = IDLE;
            code_d  = CODE_NONE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // All outputs decode the state register (or registered data), so mem_req
   // falls as soon as the asynchronous reset forces state_q to IDLE.
   assign bus.cpu_req_ready  = (state_q == IDLE);
   assign bus.busy           = (state_q != IDLE);
   assign bus.cpu_resp_valid = (state_q == RESP);
   assign bus.cpu_err        = (state_q == ERR);
   assign bus.cpu_err_code   = code_q;
   assign bus.cpu_resp_rdata = rdata_q;
   assign bus.mem_req        = (state_q == REQ);
   assign bus.mem_write      = (state_q == REQ) & write_q;
   assign bus.mem_addr       = (state_q == REQ) ? addr_q  : 32'd0;
   assign bus.mem_wdata      = (state_q == REQ) ? wdata_q : 32'd0;
   assign dbg_state          = state_q;

endmodule

// File: doc/lsu_initiator.md
Name: lsu_initiator

Overview:
- Load/store initiator between the CPU datapath and the word-addressed data memory.
- Accepts one lw/sw request at a time from the core, with the address taken from the ALU result and the store data from regB.
- Checks alignment and range, then drives a valid/ack request to the memory responder and holds it until acknowledged or timed out.
- Returns load data or an error code to the core; busy status drives the core stall.

Parameters:
- TIMEOUT_CYCLES, 15, max REQ-state cycles without mem_ack before the access is aborted (legal range 1..255).
- ADDR_LIMIT, 1024, byte-address bound; an access is legal only if addr < ADDR_LIMIT (256 words).

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst_lsu_n  input  1  asynchronous active-low reset
- cpu_req_valid  input  1  core presents a request
- cpu_req_ready  output  1  initiator can accept a request (IDLE only)
- cpu_req_write  input  1  1 = sw, 0 = lw
- cpu_req_addr  input  32  byte address (ALU result)
- cpu_req_wdata  input  32  store data
- cpu_resp_valid  output  1  one-cycle pulse, access completed OK
- cpu_resp_rdata  output  32  load data; 0 for stores
- cpu_err  output  1  one-cycle pulse, access failed
- cpu_err_code  output  2  01 misaligned, 10 timeout, 11 out of range, 00 none
- busy  output  1  state != IDLE (core stall)
- mem_req  output  1  request valid to memory
- mem_write  output  1  write enable qualifier
- mem_addr  output  32  byte address to memory
- mem_wdata  output  32  write data to memory
- mem_ack  input  1  responder completes access this cycle
- mem_rdata  input  32  read data, valid when mem_ack=1 and mem_write=0

Behaviour:
- Reset (async, rst_lsu_n=0):
  - state=IDLE; timeout counter=0; all data/address registers=0.
  - cpu_req_ready=1 once reset is released; every other output=0.
  - mem_req drops immediately, without waiting for clk.
- States: IDLE, REQ, RESP, ERR.
- IDLE:
  - cpu_req_ready=1.
  - Accept on cpu_req_valid && cpu_req_ready at a rising edge; latch write, addr and wdata.
  - If addr[1:0]!=0 → ERR, code 01. Misalignment has priority over range.
  - Else if addr >= ADDR_LIMIT (32-bit unsigned compare) → ERR, code 11.
  - Else → REQ, counter cleared.
- REQ:
  - mem_req=1; mem_write, mem_addr, mem_wdata come from the latches and stay stable until the state is left.
  - mem_ack=1 → RESP. For a load, capture mem_rdata into cpu_resp_rdata; for a store, cpu_resp_rdata=0.
  - mem_ack=0 → counter++. When the counter reaches TIMEOUT_CYCLES → ERR, code 10.
  - An ack in the TIMEOUT_CYCLES-th REQ cycle succeeds: ack wins over timeout.
- RESP: cpu_resp_valid=1 for exactly one cycle → IDLE.
- ERR:
  - cpu_err=1 with cpu_err_code for exactly one cycle → IDLE.
  - No mem_req is issued for misaligned or out-of-range accesses.
- Outputs are registered from state.
  - cpu_resp_rdata holds its value until the next completed access.
  - cpu_err_code returns to 00 when leaving ERR.
- mem_req, mem_write, mem_addr and mem_wdata are 0 outside REQ.
- Latency (accept edge = cycle T):
  - mem_req high from T+1.
  - Ack at cycle A → cpu_resp_valid at A+1.
  - Zero-wait responder (ack in first REQ cycle) → resp at T+2.
  - Range/alignment error pulse at T+1.
- cpu_req_valid is ignored while busy=1; the core holds its request until cpu_req_ready.
- Back-to-back: a new request can be accepted on the cycle IDLE is re-entered. Minimum 3 cycles per successful access.
- mem_ack outside REQ is ignored.
- Reset asserted mid-REQ aborts the access. No resp/err pulse is generated; the bench verifies the memory side separately.

Test Plan:
1. Zero-wait responder. sw addr 0x0000_0010 data 0xDEAD_BEEF, then lw 0x0000_0010 → mem_req for 1 cycle each, cpu_resp_valid at T+2, load returns 0xDEAD_BEEF, store resp_rdata=0.
2. Responder acks after 3 wait cycles on lw 0x0000_03FC (data 0x1234_5678) → mem_req high 4 cycles with stable addr, resp_valid one cycle after ack, rdata=0x1234_5678, busy high throughout.
3. lw addr 0x0000_0006 → no mem_req, cpu_err pulse at T+1 with code 01. lw addr 0x0000_0400 → code 11. Addr 0x0000_0402 → code 01 (priority).
4. Responder never acks, TIMEOUT_CYCLES=15 → mem_req high exactly 15 cycles, then cpu_err code 10, then IDLE with cpu_req_ready=1. Repeat with ack in the 15th cycle → success, no error.
5. Drop rst_lsu_n mid-REQ (between edges) → mem_req=0 immediately, no resp/err pulse; after release, state is IDLE and cpu_req_ready=1.
6. Core holds cpu_req_valid continuously with 4 alternating sw/lw requests, zero-wait responder → each accepted on IDLE re-entry, one access every 3 cycles, no request dropped or duplicated.
